wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage of the five-stage RV64 pipeline, directly downstream of the mem stage.
- Captures the mem-stage results in a MEM/WB pipeline register, aligns and sign/zero-extends load data, and selects the writeback value (ALU result, load, or pc+4).
- Drives the register-file write port, which is also the forwarding source.
- Counts retired instructions and raises a sticky halt when an ebreak retires.

Parameters:
XLEN, 64, datapath width in bits.
CNT_W, 64, retire counter width in bits.

Ports:
sys_clk  in  1  clock, rising edge.
sys_rst  in  1  asynchronous reset, active low.
stall  in  1  hold the MEM/WB register (hazard unit).
flush  in  1  insert a bubble into the MEM/WB register.
mem_valid  in  1  mem-stage slot holds a real instruction.
mem_wb_select  in  2  source select: 00 ALU, 01 load, 10 pc+4, 11 zero.
mem_alu_res  in  XLEN  ALU result; also the load address.
mem_pc_plus_4  in  XLEN  pc+4 of the instruction.
mem_now_pc  in  XLEN  pc of the instruction.
mem_load_data  in  XLEN  raw aligned doubleword read from dmem.
mem_load_funct3  in  3  load size/sign: LB 000, LH 001, LW 010, LD 011, LBU 100, LHU 101, LWU 110.
mem_rd  in  5  destination register.
mem_rd_we  in  1  instruction writes rd.
mem_ebreak  in  1  instruction is ebreak.
wb_valid  out  1  registered valid.
wb_rd  out  5  register-file write address.
wb_rd_we  out  1  register-file write enable.
write_back_data  out  XLEN  register-file write data.
wb_now_pc  out  XLEN  pc of the retiring instruction.
wb_misaligned  out  1  retiring load was misaligned.
retire_count  out  CNT_W  number of retired instructions.
ebreak  out  1  sticky halt flag.

Behaviour:
- Reset: sys_rst low asynchronously clears every output and internal register to 0. Release is sampled on the next rising edge.
- Latency: 1 cycle. All outputs are flops; load formatting and the source mux are combinational on the mem_* inputs, ahead of the register.
- Capture rule, each rising edge:
  - flush=1: wb_valid and wb_rd_we go to 0; the other data fields are don't-care. flush has priority over stall.
  - flush=0, stall=1: all MEM/WB fields hold their values. retire_count and ebreak do not change, so there is no double count.
  - otherwise: capture from the mem_* inputs.
- Load formatting:
  - off = mem_alu_res[2:0].
  - shifted = mem_load_data >> (off*8).
  - LB/LH/LW sign-extend bits 7/15/31 to XLEN. LBU/LHU/LWU zero-extend.
  - LD uses shifted as is.
  - funct3 111 yields 0.
- Misalignment: a load is misaligned when off is not a multiple of its size in bytes (H: off[0]≠0; W: off[1:0]≠0; D: off≠0).
  - A valid misaligned load captures wb_misaligned=1 and wb_rd_we=0.
  - write_back_data still holds the formatted value.
- Write enable: wb_rd_we = mem_valid & mem_rd_we & (mem_rd≠0) & ~misaligned & ~halted, where halted is the current value of ebreak.
  - write_back_data is forced to 0 when mem_rd=0.
- Retire: an instruction retires on the edge where a valid, unflushed, unstalled slot is captured while ebreak=0.
  - retire_count increments by 1 on each retire and wraps modulo 2^CNT_W.
  - A misaligned load still retires.
- Halt:
  - A retiring instruction with mem_ebreak=1 sets ebreak=1 on that edge and is itself counted.
  - From the next edge on, no retire occurs: wb_rd_we=0 and retire_count is frozen. wb_valid keeps tracking captures.
  - Only reset clears ebreak.
- Reset mid-operation: all state is discarded immediately and there is no partial write. wb_rd_we must be 0 while sys_rst is low.

Test Plan:
- LB sign: alu_res=...03, load_data=0x0000_0000_8000_0000, rd=5, sel=01 → next cycle wb_rd=5, wb_rd_we=1, write_back_data=0xFFFF_FFFF_FFFF_FF80. With LBU the data is 0x80.
- LW at off=4: load_data=0x1234_5678_0000_0000, funct3=010 → 0x0000_0000_1234_5678. LH at off=1 → wb_misaligned=1, wb_rd_we=0, retire_count increments.
- Mux and x0:
  - sel=10, pc_plus_4=0x8000_0004 → data 0x8000_0004.
  - sel=00 with rd=0 → wb_rd_we=0, data 0.
  - sel=11 → data 0.
- Stall/flush: capture instr A, then hold stall=1 for 3 cycles with new inputs → outputs stay at A and retire_count rises only by 1. Assert stall=1 and flush=1 together → wb_valid=0 and no retire.
- Halt: retire 4 instructions, the 4th with ebreak → ebreak=1 and retire_count=4. Then 3 more valid writes → wb_rd_we=0 and count stays 4. Pulse sys_rst low → all outputs 0.
- Wrap and async reset: with CNT_W=4 and 16 retires → retire_count=0. Assert sys_rst low between clock edges → outputs clear before the next edge.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: RV64 writeback stage. It holds the MEM/WB register, formats load data,
// drives the register-file write port, counts retired instructions and latches a sticky ebreak halt.
module wb_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 64
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic [1:0]       mem_wb_select,
    input  logic [XLEN-1:0]  mem_alu_res,
    input  logic [XLEN-1:0]  mem_pc_plus_4,
    input  logic [XLEN-1:0]  mem_now_pc,
    input  logic [XLEN-1:0]  mem_load_data,
    input  logic [2:0]       mem_load_funct3,
    input  logic [4:0]       mem_rd,
    input  logic             mem_rd_we,
    input  logic             mem_ebreak,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic             wb_rd_we,
    output logic [XLEN-1:0]  write_back_data,
    output logic [XLEN-1:0]  wb_now_pc,
    output logic             wb_misaligned,
    output logic [CNT_W-1:0] retire_count,
    output logic             ebreak
);
    logic [2:0]      off;
    logic [XLEN-1:0] shifted, ld_fmt, src, wb_data_n;
    logic            is_load, mis, we_n, retire;

    always_comb begin
        off       = mem_alu_res[2:0];
        shifted   = mem_load_data >> {off, 3'b000};
        ld_fmt    = mem_load_funct3 == 3'b000 ? {{(XLEN-8){shifted[7]}}, shifted[7:0]} :
                    mem_load_funct3 == 3'b001 ? {{(XLEN-16){shifted[15]}}, shifted[15:0]} :
                    mem_load_funct3 == 3'b010 ? {{(XLEN-32){shifted[31]}}, shifted[31:0]} :
                    mem_load_funct3 == 3'b011 ? shifted :
                    mem_load_funct3 == 3'b100 ? {{(XLEN-8){1'b0}}, shifted[7:0]} :
                    mem_load_funct3 == 3'b101 ? {{(XLEN-16){1'b0}}, shifted[15:0]} :
                    mem_load_funct3 == 3'b110 ? {{(XLEN-32){1'b0}}, shifted[31:0]} : '0;
        is_load   = mem_wb_select == 2'b01;
        // funct3[1:0] encodes the access size for both signed and unsigned loads
        mis       = is_load & (mem_load_funct3 != 3'b111) &
                    (mem_load_funct3[1:0] == 2'b01 ? off[0] :
                     mem_load_funct3[1:0] == 2'b10 ? |off[1:0] :
                     mem_load_funct3[1:0] == 2'b11 ? |off : 1'b0);
        src       = mem_wb_select == 2'b00 ? mem_alu_res :
                    mem_wb_select == 2'b01 ? ld_fmt :
                    mem_wb_select == 2'b10 ? mem_pc_plus_4 : '0;
        wb_data_n = mem_rd == 5'd0 ? '0 : src;
        we_n      = mem_valid & mem_rd_we & (mem_rd != 5'd0) & ~mis & ~ebreak;
        retire    = ~flush & ~stall & mem_valid & ~ebreak;
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wb_valid        <= 1'b0;
            wb_rd           <= '0;
            wb_rd_we        <= 1'b0;
            write_back_data <= '0;
            wb_now_pc       <= '0;
            wb_misaligned   <= 1'b0;
            retire_count    <= '0;
            ebreak          <= 1'b0;
        end else begin
            if (flush) begin
                wb_valid      <= 1'b0;
                wb_rd_we      <= 1'b0;
                wb_misaligned <= 1'b0;
            end else if (!stall) begin
                wb_valid        <= mem_valid;
                wb_rd           <= mem_rd;
                wb_rd_we        <= we_n;
                write_back_data <= wb_data_n;
                wb_now_pc       <= mem_now_pc;
                wb_misaligned   <= mem_valid & mis;
            end
            if (retire) begin
                retire_count <= retire_count + CNT_W'(1);
                if (mem_ebreak) ebreak <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed checks of wb_stage; a second CNT_W=4 instance shares all inputs for wrap checks.
module tb_wb_stage;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, mem_valid = 1'b0, mem_rd_we = 1'b0, mem_ebreak = 1'b0;
    logic [1:0]  mem_wb_select = '0;
    logic [63:0] mem_alu_res = '0, mem_pc_plus_4 = '0, mem_now_pc = '0, mem_load_data = '0;
    logic [2:0]  mem_load_funct3 = '0;
    logic [4:0]  mem_rd = '0;
    logic        wb_valid, wb_rd_we, wb_misaligned, ebreak;
    logic [4:0]  wb_rd;
    logic [63:0] write_back_data, wb_now_pc, retire_count;
    logic        d4_valid, d4_rd_we, d4_mis, d4_ebreak;
    logic [4:0]  d4_rd;
    logic [63:0] d4_data, d4_pc;
    logic [3:0]  d4_count;
    int          checks = 0, errors = 0;

    always #5 sys_clk = ~sys_clk;

    wb_stage dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_wb_select(mem_wb_select), .mem_alu_res(mem_alu_res),
        .mem_pc_plus_4(mem_pc_plus_4), .mem_now_pc(mem_now_pc), .mem_load_data(mem_load_data),
        .mem_load_funct3(mem_load_funct3), .mem_rd(mem_rd), .mem_rd_we(mem_rd_we),
        .mem_ebreak(mem_ebreak), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rd_we(wb_rd_we),
        .write_back_data(write_back_data), .wb_now_pc(wb_now_pc), .wb_misaligned(wb_misaligned),
        .retire_count(retire_count), .ebreak(ebreak)
    );

    wb_stage #(.XLEN(64), .CNT_W(4)) dut4 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_wb_select(mem_wb_select), .mem_alu_res(mem_alu_res),
        .mem_pc_plus_4(mem_pc_plus_4), .mem_now_pc(mem_now_pc), .mem_load_data(mem_load_data),
        .mem_load_funct3(mem_load_funct3), .mem_rd(mem_rd), .mem_rd_we(mem_rd_we),
        .mem_ebreak(mem_ebreak), .wb_valid(d4_valid), .wb_rd(d4_rd), .wb_rd_we(d4_rd_we),
        .write_back_data(d4_data), .wb_now_pc(d4_pc), .wb_misaligned(d4_mis),
        .retire_count(d4_count), .ebreak(d4_ebreak)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [63:0] alu, pc4, pc, ld,
                         input logic [2:0] f3, input logic [4:0] rd, input logic we, eb);
        mem_valid = v; mem_wb_select = sel; mem_alu_res = alu; mem_pc_plus_4 = pc4;
        mem_now_pc = pc; mem_load_data = ld; mem_load_funct3 = f3; mem_rd = rd;
        mem_rd_we = we; mem_ebreak = eb;
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #3;
        check("rst_valid", 64'(wb_valid), 64'd0);
        check("rst_we", 64'(wb_rd_we), 64'd0);
        check("rst_data", write_back_data, 64'd0);
        check("rst_count", retire_count, 64'd0);
        check("rst_ebreak", 64'(ebreak), 64'd0);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        // loads
        drive(1, 2'b01, 64'h3, 64'h8, 64'h4, 64'h0000_0000_8000_0000, 3'b000, 5'd5, 1, 0);
        tick;
        check("lb_rd", 64'(wb_rd), 64'd5);
        check("lb_we", 64'(wb_rd_we), 64'd1);
        check("lb_data", write_back_data, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_valid", 64'(wb_valid), 64'd1);
        check("lb_pc", wb_now_pc, 64'h4);
        check("lb_count", retire_count, 64'd1);
        mem_load_funct3 = 3'b100;
        tick;
        check("lbu_data", write_back_data, 64'h80);
        drive(1, 2'b01, 64'h4, 64'h8, 64'h8, 64'h1234_5678_0000_0000, 3'b010, 5'd6, 1, 0);
        tick;
        check("lw_data", write_back_data, 64'h1234_5678);
        check("lw_mis", 64'(wb_misaligned), 64'd0);
        drive(1, 2'b01, 64'h0, 64'h8, 64'h8, 64'h8877_6655_4433_2211, 3'b011, 5'd6, 1, 0);
        tick;
        check("ld_data", write_back_data, 64'h8877_6655_4433_2211);
        drive(1, 2'b01, 64'h2, 64'h8, 64'h8, 64'h0000_0000_8000_0000, 3'b001, 5'd6, 1, 0);
        tick;
        check("lh_data", write_back_data, 64'hFFFF_FFFF_FFFF_8000);
        drive(1, 2'b01, 64'h1, 64'h8, 64'h8, 64'h0000_0000_0000_8000, 3'b001, 5'd6, 1, 0);
        tick;
        check("lh_mis", 64'(wb_misaligned), 64'd1);
        check("lh_mis_we", 64'(wb_rd_we), 64'd0);
        check("lh_mis_data", write_back_data, 64'h80);
        check("lh_mis_count", retire_count, 64'd6);
        drive(1, 2'b01, 64'h4, 64'h8, 64'h8, 64'hFFFF_FFFF_FFFF_FFFF, 3'b111, 5'd6, 1, 0);
        tick;
        check("f3_111_data", write_back_data, 64'd0);
        check("f3_111_mis", 64'(wb_misaligned), 64'd0);
        // source mux and x0
        drive(1, 2'b10, 64'h99, 64'h8000_0004, 64'h8000_0000, 64'h0, 3'b000, 5'd1, 1, 0);
        tick;
        check("pc4_data", write_back_data, 64'h8000_0004);
        check("pc4_we", 64'(wb_rd_we), 64'd1);
        drive(1, 2'b00, 64'h1234, 64'h0, 64'h0, 64'h0, 3'b000, 5'd0, 1, 0);
        tick;
        check("x0_we", 64'(wb_rd_we), 64'd0);
        check("x0_data", write_back_data, 64'd0);
        drive(1, 2'b11, 64'h55, 64'h0, 64'h0, 64'h0, 3'b000, 5'd3, 1, 0);
        tick;
        check("sel11_data", write_back_data, 64'd0);
        drive(1, 2'b00, 64'hDEAD, 64'h0, 64'h0, 64'h0, 3'b000, 5'd7, 1, 0);
        tick;
        check("alu_data", write_back_data, 64'hDEAD);
        check("alu_count", retire_count, 64'd11);
        drive(0, 2'b00, 64'hBEEF, 64'h0, 64'h0, 64'h0, 3'b000, 5'd7, 1, 0);
        tick;
        check("bubble_valid", 64'(wb_valid), 64'd0);
        check("bubble_we", 64'(wb_rd_we), 64'd0);
        check("bubble_count", retire_count, 64'd11);
        // stall and flush
        drive(1, 2'b00, 64'hAAAA, 64'h0, 64'h100, 64'h0, 3'b000, 5'd9, 1, 0);
        tick;
        stall = 1'b1;
        drive(1, 2'b00, 64'hBBBB, 64'h0, 64'h200, 64'h0, 3'b000, 5'd10, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("stall_data", write_back_data, 64'hAAAA);
        end
        check("stall_rd", 64'(wb_rd), 64'd9);
        check("stall_pc", wb_now_pc, 64'h100);
        check("stall_count", retire_count, 64'd12);
        flush = 1'b1;
        tick;
        check("flush_valid", 64'(wb_valid), 64'd0);
        check("flush_we", 64'(wb_rd_we), 64'd0);
        check("flush_count", retire_count, 64'd12);
        stall = 1'b0; flush = 1'b0;
        // four more retires wrap the 4-bit counter
        drive(1, 2'b00, 64'h1, 64'h0, 64'h300, 64'h0, 3'b000, 5'd2, 1, 0);
        for (int i = 0; i < 4; i++) tick;
        check("wrap_count4", 64'(d4_count), 64'd0);
        check("count16", retire_count, 64'd16);
        // halt
        for (int i = 0; i < 3; i++) tick;
        drive(1, 2'b00, 64'h0, 64'h0, 64'h400, 64'h0, 3'b000, 5'd0, 0, 1);
        tick;
        check("halt_flag", 64'(ebreak), 64'd1);
        check("halt_count", retire_count, 64'd20);
        check("halt_count4", 64'(d4_count), 64'd4);
        drive(1, 2'b00, 64'h77, 64'h0, 64'h404, 64'h0, 3'b000, 5'd4, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("halted_we", 64'(wb_rd_we), 64'd0);
        end
        check("halted_valid", 64'(wb_valid), 64'd1);
        check("halted_count", retire_count, 64'd20);
        check("halted_flag", 64'(ebreak), 64'd1);
        // asynchronous reset between edges
        #2 sys_rst = 1'b0;
        #1;
        check("arst_valid", 64'(wb_valid), 64'd0);
        check("arst_we", 64'(wb_rd_we), 64'd0);
        check("arst_data", write_back_data, 64'd0);
        check("arst_pc", wb_now_pc, 64'd0);
        check("arst_count", retire_count, 64'd0);
        check("arst_ebreak", 64'(ebreak), 64'd0);
        tick;
        check("rst_hold_we", 64'(wb_rd_we), 64'd0);
        check("rst_hold_count", retire_count, 64'd0);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        tick;
        check("post_rst_we", 64'(wb_rd_we), 64'd1);
        check("post_rst_data", write_back_data, 64'h77);
        check("post_rst_count", retire_count, 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
